// File: rtl/led_chase_game.sv
// -----------------------------------------------------------------------------
// led_chase_game
//
// Reaction game: a single lit LED chases across N_LEDS positions and the
// player must raise the switch under the lit LED. Every HITS_PER_LEVEL hits
// the chase speeds up (the step period halves per level). MAX_MISS misses
// ends the game (OVER); clearing the final level wins it (WIN). The score is
// kept in BCD and shown on two active-low 7-segment digits, the level on a
// third.
//
// Ports
//   clock       sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       level-sensitive arm; high forces IDLE and clears counters,
//               its falling edge launches a game
//   switch      player switches, only rising edges are events
//   led         LED drive (one-hot chase in RUN, all on in WIN, off otherwise)
//   point_msb   score tens digit, 7-seg active-low gfedcba
//   point_lsb   score units digit, same encoding
//   level_out   current level digit, same encoding
//   game_state  0 = IDLE, 1 = RUN, 2 = WIN, 3 = OVER
// -----------------------------------------------------------------------------
module led_chase_game #(
   parameter int N_LEDS         = 10,
   parameter int BASE_TICKS     = 8,
   parameter int LEVELS         = 4,
   parameter int HITS_PER_LEVEL = 4,
   parameter int MAX_MISS       = 3,
   parameter int HOLD_TICKS     = 16,
   parameter int MODE           = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [N_LEDS-1:0] switch,
   output logic [N_LEDS-1:0] led,
   output logic [6:0]        point_msb,
   output logic [6:0]        point_lsb,
   output logic [6:0]        level_out,
   output logic [1:0]        game_state
);

   localparam int TMR_W  = $clog2(BASE_TICKS) + 1;
   localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam int HIT_W  = $clog2(HITS_PER_LEVEL + 1);
   localparam int MISS_W = $clog2(MAX_MISS + 1);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WIN  = 2'd2,
      S_OVER = 2'd3
   } state_t;

   // Active-low gfedcba pattern for a decimal digit; blank for non-digits.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Clocks per LED step at a given level: BASE_TICKS >> level, floored at 1.
   function automatic logic [TMR_W-1:0] period(input logic [LVL_W-1:0] lvl);
      logic [TMR_W-1:0] p;
      p = TMR_W'(BASE_TICKS) >> lvl;
      if (p == '0) begin
         p = TMR_W'(1);
      end
      return p;
   endfunction

   state_t              state_q, state_d;
   logic [N_LEDS-1:0]   led_q, led_d;
   logic                dir_q, dir_d;          // 0 = moving up, 1 = moving down
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [3:0]          tens_q, tens_d;
   logic [3:0]          ones_q, ones_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [MISS_W-1:0]   miss_q, miss_d;
   logic [HIT_W-1:0]    hit_q, hit_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [N_LEDS-1:0]   switch_q, switch_d;
   logic                start_q, start_d;
   logic [6:0]          point_msb_q, point_msb_d;
   logic [6:0]          point_lsb_q, point_lsb_d;
   logic [6:0]          level_out_q, level_out_d;

   logic [N_LEDS-1:0]   rise;
   logic                do_adv;
   logic [HIT_W-1:0]    hit_inc;
   logic [MISS_W-1:0]   miss_inc;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         led_q       <= '0;
         dir_q       <= 1'b0;
         timer_q     <= '0;
         tens_q      <= '0;
         ones_q      <= '0;
         level_q     <= '0;
         miss_q      <= '0;
         hit_q       <= '0;
         hold_q      <= '0;
         switch_q    <= '0;
         start_q     <= 1'b0;
         point_msb_q <= 7'h40;
         point_lsb_q <= 7'h40;
         level_out_q <= 7'h40;
      end else begin
         state_q     <= state_d;
         led_q       <= led_d;
         dir_q       <= dir_d;
         timer_q     <= timer_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         level_q     <= level_d;
         miss_q      <= miss_d;
         hit_q       <= hit_d;
         hold_q      <= hold_d;
         switch_q    <= switch_d;
         start_q     <= start_d;
         point_msb_q <= point_msb_d;
         point_lsb_q <= point_lsb_d;
         level_out_q <= level_out_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      led_d    = led_q;
      dir_d    = dir_q;
      timer_d  = timer_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      level_d  = level_q;
      miss_d   = miss_q;
      hit_d    = hit_q;
      hold_d   = hold_q;
      switch_d = switch;
      start_d  = start;
      rise     = switch & ~switch_q;
      do_adv   = 1'b0;
      hit_inc  = hit_q + HIT_W'(1);
      miss_inc = miss_q + MISS_W'(1);

      case (state_q)
         S_IDLE: begin
            led_d = '0;
            // Launch on the falling edge of start.
            if (!start && start_q) begin
               state_d = S_RUN;
               led_d   = N_LEDS'(1);
               dir_d   = 1'b0;
               timer_d = period(level_q);
            end
         end

         S_RUN: begin
            if (timer_q == TMR_W'(1)) begin
               do_adv = 1'b1;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end

            if (rise != '0) begin
               if (rise == led_q) begin
                  // A hit shares do_adv with timer expiry: one step only.
                  do_adv = 1'b1;
                  if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
                     if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                     end else begin
                        ones_d = ones_q + 4'd1;
                     end
                  end
                  if (hit_inc == HIT_W'(HITS_PER_LEVEL)) begin
                     hit_d = '0;
                     if (level_q == LVL_W'(LEVELS - 1)) begin
                        state_d = S_WIN;
                        hold_d  = HOLD_W'(HOLD_TICKS - 1);
                     end else begin
                        level_d = level_q + LVL_W'(1);
                     end
                  end else begin
                     hit_d = hit_inc;
                  end
               end else begin
                  miss_d = miss_inc;
                  if (miss_inc == MISS_W'(MAX_MISS)) begin
                     state_d = S_OVER;
                     hold_d  = HOLD_W'(HOLD_TICKS - 1);
                  end
               end
            end

            if (state_d == S_WIN) begin
               led_d = '1;
            end else if (state_d == S_OVER) begin
               led_d = '0;
            end else if (do_adv) begin
               // Reload uses level_d so a level-up speeds up immediately.
               timer_d = period(level_d);
               if (MODE == 0) begin
                  led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
               end else if (!dir_q) begin
                  if (led_q[N_LEDS-1]) begin
                     led_d = led_q >> 1;
                     dir_d = 1'b1;
                  end else begin
                     led_d = led_q << 1;
                  end
               end else begin
                  if (led_q[0]) begin
                     led_d = led_q << 1;
                     dir_d = 1'b0;
                  end else begin
                     led_d = led_q >> 1;
                  end
               end
            end
         end

         S_WIN, S_OVER: begin
            led_d = (state_q == S_WIN) ? '1 : '0;
            if (hold_q == '0) begin
               state_d = S_IDLE;
               led_d   = '0;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            led_d   = '0;
         end
      endcase

      // start held high overrides everything: back to IDLE, fresh game.
      if (start) begin
         state_d = S_IDLE;
         led_d   = '0;
         dir_d   = 1'b0;
         timer_d = '0;
         tens_d  = '0;
         ones_d  = '0;
         level_d = '0;
         miss_d  = '0;
         hit_d   = '0;
         hold_d  = '0;
      end

      point_msb_d = seg7(tens_d);
      point_lsb_d = seg7(ones_d);
      level_out_d = seg7(4'(level_d));
   end

   assign led        = led_q;
   assign point_msb  = point_msb_q;
   assign point_lsb  = point_lsb_q;
   assign level_out  = level_out_q;
   assign game_state = state_q;

endmodule

// File: tb/tb_led_chase_game.sv
module tb_led_chase_game;

   typedef struct {
      int         cyc;
      logic       strt;
      logic [9:0] sw;
      logic [1:0] st;
      logic [9:0] led;
      logic [6:0] msb;
      logic [6:0] lsb;
      logic [6:0] lvl;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       start0, start1;
   logic [9:0] switch0, switch1;
   logic [9:0] led0, led1;
   logic [6:0] msb0, lsb0, lvl0, msb1, lsb1, lvl1;
   logic [1:0] st0, st1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always #5 clock = ~clock;

   led_chase_game dut0 (
      .clock(clock), .reset_n(reset_n), .start(start0), .switch(switch0),
      .led(led0), .point_msb(msb0), .point_lsb(lsb0), .level_out(lvl0),
      .game_state(st0)
   );

   led_chase_game #(.MODE(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .start(start1), .switch(switch1),
      .led(led1), .point_msb(msb1), .point_lsb(lsb1), .level_out(lvl1),
      .game_state(st1)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic vec_t mk(input int c, input logic s, input logic [9:0] sw,
                               input logic [1:0] st, input logic [9:0] l,
                               input logic [6:0] m, input logic [6:0] ls,
                               input logic [6:0] lv);
      vec_t v;
      v.cyc = c; v.strt = s; v.sw = sw; v.st = st; v.led = l;
      v.msb = m; v.lsb = ls; v.lvl = lv;
      return v;
   endfunction

   vec_t vecs [17];
   logic [9:0] targets [12] = '{10'h020, 10'h040, 10'h080, 10'h100, 10'h200, 10'h001,
                                10'h002, 10'h004, 10'h010, 10'h040, 10'h100, 10'h001};

   initial begin
      // Launch, chase timing with wrap, then four hits into level 1.
      vecs[0]  = mk(8, 1'b1, 10'h000, 2'd0, 10'h000, 7'h40, 7'h40, 7'h40);
      vecs[1]  = mk(1, 1'b0, 10'h000, 2'd1, 10'h001, 7'h40, 7'h40, 7'h40);
      vecs[2]  = mk(7, 1'b0, 10'h000, 2'd1, 10'h001, 7'h40, 7'h40, 7'h40);
      vecs[3]  = mk(1, 1'b0, 10'h000, 2'd1, 10'h002, 7'h40, 7'h40, 7'h40);
      vecs[4]  = mk(8, 1'b0, 10'h000, 2'd1, 10'h004, 7'h40, 7'h40, 7'h40);
      vecs[5]  = mk(56, 1'b0, 10'h000, 2'd1, 10'h200, 7'h40, 7'h40, 7'h40);
      vecs[6]  = mk(7, 1'b0, 10'h000, 2'd1, 10'h200, 7'h40, 7'h40, 7'h40);
      vecs[7]  = mk(1, 1'b0, 10'h000, 2'd1, 10'h001, 7'h40, 7'h40, 7'h40);
      vecs[8]  = mk(1, 1'b0, 10'h001, 2'd1, 10'h002, 7'h40, 7'h79, 7'h40);
      vecs[9]  = mk(1, 1'b0, 10'h000, 2'd1, 10'h002, 7'h40, 7'h79, 7'h40);
      vecs[10] = mk(1, 1'b0, 10'h002, 2'd1, 10'h004, 7'h40, 7'h24, 7'h40);
      vecs[11] = mk(1, 1'b0, 10'h000, 2'd1, 10'h004, 7'h40, 7'h24, 7'h40);
      vecs[12] = mk(1, 1'b0, 10'h004, 2'd1, 10'h008, 7'h40, 7'h30, 7'h40);
      vecs[13] = mk(1, 1'b0, 10'h000, 2'd1, 10'h008, 7'h40, 7'h30, 7'h40);
      vecs[14] = mk(1, 1'b0, 10'h008, 2'd1, 10'h010, 7'h40, 7'h19, 7'h79);
      vecs[15] = mk(3, 1'b0, 10'h000, 2'd1, 10'h010, 7'h40, 7'h19, 7'h79);
      vecs[16] = mk(1, 1'b0, 10'h000, 2'd1, 10'h020, 7'h40, 7'h19, 7'h79);

      reset_n = 1'b0;
      start0 = 1'b0; start1 = 1'b0;
      switch0 = '0; switch1 = '0;
      tick(2);
      chk("reset_state", 32'(st0), 32'd0);
      chk("reset_led", 32'(led0), 32'h0);
      chk("reset_msb", 32'(msb0), 32'h40);
      chk("reset_lsb", 32'(lsb0), 32'h40);
      chk("reset_lvl", 32'(lvl0), 32'h40);
      reset_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         start0  = vecs[i].strt;
         switch0 = vecs[i].sw;
         tick(vecs[i].cyc);
         chk($sformatf("vec%0d_state", i), 32'(st0),  32'(vecs[i].st));
         chk($sformatf("vec%0d_led", i),   32'(led0), 32'(vecs[i].led));
         chk($sformatf("vec%0d_msb", i),   32'(msb0), 32'(vecs[i].msb));
         chk($sformatf("vec%0d_lsb", i),   32'(lsb0), 32'(vecs[i].lsb));
         chk($sformatf("vec%0d_lvl", i),   32'(lvl0), 32'(vecs[i].lvl));
      end

      // Twelve more hits through levels 1..3 (periods 4, 2, 1) into WIN.
      for (int i = 0; i < 12; i++) begin
         int sc;
         int lv;
         sc = 5 + i;
         lv = (i < 3) ? 1 : (i < 7) ? 2 : 3;
         switch0 = targets[i];
         tick(1);
         chk($sformatf("hit%0d_state", i), 32'(st0), (i == 11) ? 32'd2 : 32'd1);
         chk($sformatf("hit%0d_msb", i), 32'(msb0), 32'(seg_tab[sc / 10]));
         chk($sformatf("hit%0d_lsb", i), 32'(lsb0), 32'(seg_tab[sc % 10]));
         chk($sformatf("hit%0d_lvl", i), 32'(lvl0), 32'(seg_tab[lv]));
         switch0 = '0;
         tick(1);
      end
      chk("win_led", 32'(led0), 32'h3FF);
      tick(14);
      chk("win_hold_state", 32'(st0), 32'd2);
      chk("win_hold_led", 32'(led0), 32'h3FF);
      tick(1);
      chk("win_end_state", 32'(st0), 32'd0);
      chk("win_end_led", 32'(led0), 32'h0);
      chk("win_end_msb", 32'(msb0), 32'h79);
      chk("win_end_lsb", 32'(lsb0), 32'h02);
      chk("win_end_lvl", 32'(lvl0), 32'h30);

      // One hit then three misses -> OVER, score held for display.
      start0 = 1'b1;
      tick(2);
      chk("over_clr_lsb", 32'(lsb0), 32'h40);
      chk("over_clr_msb", 32'(msb0), 32'h40);
      chk("over_clr_lvl", 32'(lvl0), 32'h40);
      start0 = 1'b0;
      tick(1);
      chk("over_run_led", 32'(led0), 32'h001);
      switch0 = 10'h001; tick(1);
      chk("over_hit_led", 32'(led0), 32'h002);
      chk("over_hit_lsb", 32'(lsb0), 32'h79);
      switch0 = '0; tick(1);
      switch0 = 10'h001; tick(1);
      chk("miss1_state", 32'(st0), 32'd1);
      chk("miss1_led", 32'(led0), 32'h002);
      switch0 = '0; tick(1);
      switch0 = 10'h004; tick(1);
      chk("miss2_state", 32'(st0), 32'd1);
      switch0 = '0; tick(1);
      switch0 = 10'h008; tick(1);
      chk("miss3_state", 32'(st0), 32'd3);
      chk("miss3_led", 32'(led0), 32'h0);
      switch0 = '0;
      tick(15);
      chk("over_hold_state", 32'(st0), 32'd3);
      tick(1);
      chk("over_end_state", 32'(st0), 32'd0);
      chk("over_end_lsb", 32'(lsb0), 32'h79);
      chk("over_end_msb", 32'(msb0), 32'h40);

      // start held high during RUN clears the game.
      start0 = 1'b1; tick(1);
      start0 = 1'b0; tick(1);
      switch0 = 10'h001; tick(1);
      chk("hold_start_score", 32'(lsb0), 32'h79);
      switch0 = '0;
      start0 = 1'b1; tick(1);
      chk("hold_start_state", 32'(st0), 32'd0);
      chk("hold_start_led", 32'(led0), 32'h0);
      chk("hold_start_lsb", 32'(lsb0), 32'h40);
      start0 = 1'b0; tick(1);
      chk("relaunch_state", 32'(st0), 32'd1);
      chk("relaunch_led", 32'(led0), 32'h001);

      // Asynchronous reset between clock edges mid-RUN.
      switch0 = 10'h001; tick(1);
      chk("pre_reset_lsb", 32'(lsb0), 32'h79);
      switch0 = '0;
      #3 reset_n = 1'b0;
      #1;
      chk("async_rst_state", 32'(st0), 32'd0);
      chk("async_rst_led", 32'(led0), 32'h0);
      chk("async_rst_lsb", 32'(lsb0), 32'h40);
      #2 reset_n = 1'b1;
      tick(3);
      chk("post_rst_idle", 32'(st0), 32'd0);
      start0 = 1'b1; tick(1);
      start0 = 1'b0; tick(1);
      chk("post_rst_run", 32'(st0), 32'd1);

      // Ping-pong chase on the MODE 1 instance.
      start1 = 1'b1; tick(1);
      start1 = 1'b0; tick(1);
      chk("pp_entry", 32'(led1), 32'h001);
      tick(72);
      chk("pp_top", 32'(led1), 32'h200);
      tick(8);
      chk("pp_reverse", 32'(led1), 32'h100);
      tick(8);
      chk("pp_down", 32'(led1), 32'h080);
      tick(7);
      chk("pp_pre_expiry", 32'(led1), 32'h080);
      switch1 = 10'h080; tick(1);
      chk("pp_hit_expiry_led", 32'(led1), 32'h040);
      chk("pp_hit_expiry_lsb", 32'(lsb1), 32'h79);
      switch1 = '0;
      tick(7);
      chk("pp_after_hit", 32'(led1), 32'h040);
      tick(1);
      chk("pp_next_step", 32'(led1), 32'h020);
      tick(40);
      chk("pp_bottom", 32'(led1), 32'h001);
      tick(8);
      chk("pp_bounce_up", 32'(led1), 32'h002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
